// File: rtl/lsu_seq_ctrl_if.sv
// Data-memory request/response bus between the LSU sequencer (master) and memory (slave).
interface lsu_seq_ctrl_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [3:0]  dmem_req_be;
  logic [31:0] dmem_req_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_be, dmem_req_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
endinterface

// File: rtl/lsu_seq_ctrl.sv
// EX-stage load/store sequencer: IDLE -> REQ -> (WAIT) -> DONE, stalling the pipeline meanwhile.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and flag misalign_out.
module lsu_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_ex,
  input  logic        mem_write_sel_ex,
  input  logic [2:0]  lsu_op_ex,
  input  logic [31:0] mem_addr_ex,
  input  logic [31:0] mem_wdata_ex,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] load_data_out,
  output logic        misalign_out,
  output logic        bus_err_out,
  lsu_seq_ctrl_if.master dmem
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           we_q, we_d;
  logic [2:0]     op_q, op_d;
  logic [1:0]     off_q, off_d;
  logic [31:0]    addr_q, addr_d;
  logic [3:0]     be_q, be_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    data_q, data_d;
  logic           err_q, err_d;

  // Lane placement of the incoming op; size comes from op[1:0] only (11 behaves as W).
  logic [1:0]  off_a;
  logic [3:0]  be_a;
  logic [31:0] wd_a;
  always_comb begin
    off_a = 2'b00;
    be_a  = 4'hF;
    wd_a  = mem_wdata_ex;
    case (lsu_op_ex[1:0])
      2'b00: begin
        off_a = mem_addr_ex[1:0];
        be_a  = 4'b0001 << mem_addr_ex[1:0];
        wd_a  = {4{mem_wdata_ex[7:0]}};
      end
      2'b01: begin
        off_a = {mem_addr_ex[1], 1'b0};
        be_a  = 4'b0011 << {mem_addr_ex[1], 1'b0};
        wd_a  = {2{mem_wdata_ex[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_a, mis_q, mis_d;
  assign mis_a = (lsu_op_ex[1:0] == 2'b01) ? mem_addr_ex[0] :
                 (lsu_op_ex[1]           ) ? |mem_addr_ex[1:0] : 1'b0;
  assign misalign_out = mis_q;
`else
  assign misalign_out = 1'b0;
`endif

  logic [31:0] sh;
  logic [31:0] ext;
  assign sh = dmem.dmem_rsp_rdata >> {off_q, 3'b000};
  always_comb begin
    case (op_q)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ext = {24'h0, sh[7:0]};
      3'b101:  ext = {16'h0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    op_d      = op_q;
    off_d     = off_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    err_d     = err_q;
`ifdef MISALIGN_TRAP_EN
    mis_d     = mis_q;
`endif
    lsu_stall = 1'b0;
    case (state_q)
      S_IDLE: if (lsu_req_ex) begin
        lsu_stall = 1'b1;
        we_d      = mem_write_sel_ex;
        op_d      = lsu_op_ex;
        off_d     = off_a;
        addr_d    = {mem_addr_ex[31:2], 2'b00};
        be_d      = be_a;
        wdata_d   = wd_a;
        cnt_d     = '0;
        data_d    = '0;
        err_d     = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d     = mis_a;
        state_d   = mis_a ? S_DONE : S_REQ;
`else
        state_d   = S_REQ;
`endif
      end
      S_REQ: begin
        lsu_stall = 1'b1;
        if (dmem.dmem_req_ready) state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        lsu_stall = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (dmem.dmem_rsp_valid) begin
          data_d  = ext;
          state_d = S_DONE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      op_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign lsu_done            = (state_q == S_DONE);
  assign load_data_out       = data_q;
  assign bus_err_out         = err_q;
  assign dmem.dmem_req_valid = (state_q == S_REQ);
  assign dmem.dmem_req_we    = we_q;
  assign dmem.dmem_req_addr  = addr_q;
  assign dmem.dmem_req_be    = be_q;
  assign dmem.dmem_req_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_seq_ctrl.sv
// Scoreboard bench for lsu_seq_ctrl: byte-level memory reference model, random bus delays.
module tb_lsu_seq_ctrl;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_ex, mem_write_sel_ex;
  logic [2:0]  lsu_op_ex;
  logic [31:0] mem_addr_ex, mem_wdata_ex;
  logic        lsu_stall, lsu_done, misalign_out, bus_err_out;
  logic [31:0] load_data_out;

  always #5 clk = ~clk;

  lsu_seq_ctrl_if bus ();

  lsu_seq_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .lsu_req_ex(lsu_req_ex), .mem_write_sel_ex(mem_write_sel_ex),
    .lsu_op_ex(lsu_op_ex), .mem_addr_ex(mem_addr_ex), .mem_wdata_ex(mem_wdata_ex),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .load_data_out(load_data_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out), .dmem(bus)
  );

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] data; logic mis; logic err; int stalls; } rsp_t;

  req_t        exp_req_q[$];
  rsp_t        exp_rsp_q[$];
  logic [7:0]  ref_b[int];
  logic [31:0] mem_w[int];
  int          cur_rdly = 0, cur_sdly = 0;
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int a);
    logic [31:0] v;
    v = 32'(a * 37 + 5);
    return v[7:0];
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    return ref_b.exists(a) ? ref_b[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] bus_rd(input int w);
    if (mem_w.exists(w)) return mem_w[w];
    return {init_byte(4*w+3), init_byte(4*w+2), init_byte(4*w+1), init_byte(4*w)};
  endfunction

  // Reference: compute expected request and completion from access size and memory bytes.
  task automatic do_op(input logic w, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] d, input int rd, input int sd);
    int n, ai, ea; bit mis, trap, ok; req_t r; rsp_t e; logic [31:0] v;
    n  = (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
    ai = int'(a);
    mis = (ai % n) != 0;
    ea = ai - (ai % n);
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    e.data = 32'h0; e.mis = trap; e.err = 1'b0; e.stalls = 1;
    if (!trap) begin
      r.we    = w;
      r.addr  = a & ~32'h3;
      r.be    = 4'(((1 << n) - 1) << (ea % 4));
      r.wdata = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
      exp_req_q.push_back(r);
      if (w) begin
        for (int i = 0; i < n; i++) ref_b[ea+i] = d[8*i +: 8];
        e.stalls = 2 + rd;
      end else if (sd >= TO) begin
        e.err = 1'b1;
        e.stalls = 2 + rd + TO;
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(ea + i);
        if (!o[2] && n < 4 && v[8*n-1])
          for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
        e.data = v;
        e.stalls = 3 + rd + sd;
      end
    end
    exp_rsp_q.push_back(e);
    cur_rdly = rd; cur_sdly = sd;
    @(posedge clk); #1;
    lsu_req_ex = 1'b1; mem_write_sel_ex = w; lsu_op_ex = o; mem_addr_ex = a; mem_wdata_ex = d;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (lsu_done) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    lsu_req_ex = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Memory slave: random ready delay, delayed response, request field checks.
  initial begin
    int wc, rsp_cd; bit in_req; req_t r, snap; logic [31:0] rsp_word;
    wc = 0; rsp_cd = -1; in_req = 1'b0; rsp_word = 32'h0;
    bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0; bus.dmem_rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.dmem_req_ready = 1'b0;
      bus.dmem_rsp_valid = 1'b0;
      bus.dmem_rsp_rdata = $urandom;
      if (rst) in_req = 1'b0;
      if (rsp_cd > 0) rsp_cd--;
      else if (rsp_cd == 0) begin
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rsp_rdata = rsp_word;
        rsp_cd = -1;
      end
      if (bus.dmem_req_valid) begin
        snap.we = bus.dmem_req_we; snap.addr = bus.dmem_req_addr;
        snap.be = bus.dmem_req_be; snap.wdata = bus.dmem_req_wdata;
        if (!in_req) begin
          in_req = 1'b1; wc = 0;
          if (exp_req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
          else begin
            r = exp_req_q.pop_front();
            chk("req_addr", bus.dmem_req_addr, r.addr);
            chk("req_be_we", 32'({bus.dmem_req_be, bus.dmem_req_we}), 32'({r.be, r.we}));
            if (r.we) chk("req_wdata", bus.dmem_req_wdata, r.wdata);
          end
        end else begin
          chk("req_stable_addr", bus.dmem_req_addr, r.addr);
          chk("req_stable_be_we", 32'({bus.dmem_req_be, bus.dmem_req_we}), 32'({r.be, r.we}));
          if (r.we) chk("req_stable_wdata", bus.dmem_req_wdata, r.wdata);
        end
        if (wc == cur_rdly) begin
          bus.dmem_req_ready = 1'b1;
          in_req = 1'b0;
          if (snap.we) begin
            rsp_word = bus_rd(int'(snap.addr >> 2));
            for (int b = 0; b < 4; b++) if (snap.be[b]) rsp_word[8*b +: 8] = snap.wdata[8*b +: 8];
            mem_w[int'(snap.addr >> 2)] = rsp_word;
          end else begin
            rsp_word = bus_rd(int'(snap.addr >> 2));
            rsp_cd = (cur_sdly > 10) ? -1 : cur_sdly;
          end
        end
        wc++;
      end
    end
  end

  // Monitor: pop expected completion on every lsu_done.
  initial begin
    int stall_cnt; rsp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) stall_cnt = 0;
      else begin
        if (lsu_stall) stall_cnt++;
        if (lsu_done) begin
          if (exp_rsp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
          else begin
            e = exp_rsp_q.pop_front();
            chk("load_data", load_data_out, e.data);
            chk("misalign", 32'(misalign_out), 32'(e.mis));
            chk("bus_err", 32'(bus_err_out), 32'(e.err));
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
          end
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_done"}, 32'(lsu_done), 32'd0);
    chk({tag, "_stall"}, 32'(lsu_stall), 32'd0);
    chk({tag, "_req_valid"}, 32'(bus.dmem_req_valid), 32'd0);
    chk({tag, "_flags"}, 32'({misalign_out, bus_err_out, bus.dmem_req_we}), 32'd0);
    chk({tag, "_data"}, load_data_out, 32'd0);
    chk({tag, "_addr"}, bus.dmem_req_addr, 32'd0);
    chk({tag, "_be_wdata"}, bus.dmem_req_wdata | 32'(bus.dmem_req_be), 32'd0);
  endtask

  initial begin
    static int sdl[9] = '{0, 1, 2, 3, 5, 7, 8, 9, 12};
    req_t r;
    rst = 1'b1; lsu_req_ex = 1'b0; mem_write_sel_ex = 1'b0; lsu_op_ex = 3'b0;
    mem_addr_ex = 32'h0; mem_wdata_ex = 32'h0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;

    do_op(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0);
    do_op(1'b1, 3'b010, 32'h200, 32'h80FFFF7F, 0, 0);
    do_op(1'b0, 3'b000, 32'h203, 32'h0, 0, 3);
    do_op(1'b0, 3'b100, 32'h203, 32'h0, 0, 3);
    do_op(1'b1, 3'b001, 32'h102, 32'h00001234, 4, 0);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 1, 0);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 12);
    do_op(1'b0, 3'b010, 32'h101, 32'h0, 0, 1);
    do_op(1'b0, 3'b111, 32'h106, 32'h0, 2, 7);
    idle(3);

    // Reset in WAIT; the pending response then arrives while idle and must be ignored.
    r.we = 1'b0; r.addr = 32'h110; r.be = 4'hF; r.wdata = 32'h0;
    exp_req_q.push_back(r);
    cur_rdly = 0; cur_sdly = 6;
    @(posedge clk); #1;
    lsu_req_ex = 1'b1; mem_write_sel_ex = 1'b0; lsu_op_ex = 3'b010; mem_addr_ex = 32'h110;
    repeat (3) @(posedge clk);
    #1; lsu_req_ex = 1'b0; rst = 1'b1;
    #1; chk_quiet("mid_reset");
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    do_op(1'b0, 3'b010, 32'h104, 32'h0, 0, 0);

    for (int t = 0; t < 200; t++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'h100 + 32'($urandom_range(0, 63)), $urandom,
            $urandom_range(0, 3), sdl[$urandom_range(0, 8)]);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    idle(15);
    chk("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);
    chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
